// File: rtl/gf2m_digit_mul_if.sv
// Start/done handshake and operand/result bus for the GF(2^M) digit-serial multiplier.
interface gf2m_digit_mul_if #(
    parameter int unsigned M = 163
);
    logic         start;
    logic [M-1:0] a_in;
    logic [M-1:0] b_in;
    logic         ready;
    logic         busy;
    logic         done;
    logic [M-1:0] result;

    modport master (
        output start, a_in, b_in,
        input  ready, busy, done, result
    );

    modport slave (
        input  start, a_in, b_in,
        output ready, busy, done, result
    );
endinterface

// File: rtl/gf2m_digit_mul.sv
// Iterative digit-serial GF(2^M) polynomial-basis multiplier: result = a*b mod f(x),
// consuming D bits of b per clock, most significant digit first.
module gf2m_digit_mul #(
    parameter int unsigned   M    = 163,
    parameter int unsigned   D    = 16,
    parameter logic [M-1:0]  POLY = 163'hC9
) (
    input  logic              clk,
    input  logic              rst,
    gf2m_digit_mul_if.slave   bus
);
    localparam int unsigned N  = (M + D - 1) / D;
    localparam int unsigned NB = N * D;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [M-1:0]  a_q, a_d;
    logic [NB-1:0] b_q, b_d;
    logic [M-1:0]  t_q, t_d;
    logic [M-1:0]  result_q, result_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [M-1:0]  t_step;

    // D chained shift-reduce-XOR stages over the current top digit of b, MSB first.
    always_comb begin
        t_step = t_q;
        for (int j = int'(D) - 1; j >= 0; j--) begin
            t_step = {t_step[M-2:0], 1'b0}
                   ^ (t_step[M-1] ? POLY : '0)
                   ^ (b_q[NB-D+j] ? a_q : '0);
        end
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        t_d      = t_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    a_d     = bus.a_in;
                    b_d     = NB'(bus.b_in);
                    t_d     = '0;
                    cnt_d   = CW'(N - 1);
                    state_d = StRun;
                end
            end
            StRun: begin
                t_d = t_step;
                b_d = b_q << D;
                if (cnt_q == '0) begin
                    result_d = t_step;
                    state_d  = StDone;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            a_q      <= '0;
            b_q      <= '0;
            t_q      <= '0;
            result_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            t_q      <= t_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.ready  = (state_q == StIdle);
    assign bus.busy   = (state_q == StRun);
    assign bus.done   = (state_q == StDone);
    assign bus.result = result_q;
endmodule

// File: tb/tb_gf2m_digit_mul.sv
// Bench for gf2m_digit_mul: fixed vectors, corner-case sequences and random operands
// checked against a full-product-then-reduce reference for D = 1, 4, 16, 163.
module tb_gf2m_digit_mul;
    localparam int unsigned  M    = 163;
    localparam logic [M-1:0] POLY = 163'hC9;
    localparam int unsigned  DV [4] = '{1, 4, 16, 163};
    localparam int unsigned  NR [4] = '{100, 300, 1000, 1000};

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   start_v;
    logic [M-1:0] a_v, b_v;
    logic         rdy [4];
    logic         bsy [4];
    logic         dn  [4];
    logic [M-1:0] res [4];

    int nvec  = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        gf2m_digit_mul_if #(.M(M)) bus ();
        assign bus.start = start_v[g];
        assign bus.a_in  = a_v;
        assign bus.b_in  = b_v;
        assign rdy[g]    = bus.ready;
        assign bsy[g]    = bus.busy;
        assign dn[g]     = bus.done;
        assign res[g]    = bus.result;
        gf2m_digit_mul #(.M(M), .D(DV[g]), .POLY(POLY)) u_dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );
    end

    // Schoolbook carry-less product, then long division by f(x) = x^M + POLY.
    function automatic logic [M-1:0] ref_mul(input logic [M-1:0] a, input logic [M-1:0] b);
        logic [2*M-2:0] p;
        logic [2*M-2:0] f;
        p = '0;
        f = (2*M-1)'({1'b1, POLY});
        for (int i = 0; i < int'(M); i++) begin
            if (b[i]) p ^= (2*M-1)'(a) << i;
        end
        for (int i = 2*int'(M) - 2; i >= int'(M); i--) begin
            if (p[i]) p ^= f << (i - int'(M));
        end
        return p[M-1:0];
    endfunction

    function automatic logic [M-1:0] rnd_op();
        logic [191:0] v;
        v = '0;
        for (int k = 0; k < 6; k++) v = {v[159:0], 32'($urandom)};
        return v[M-1:0];
    endfunction

    function automatic int exp_lat(input int sel);
        return (int'(M) + int'(DV[sel]) - 1) / int'(DV[sel]) + 2;
    endfunction

    task automatic chk(input string name, input logic [M-1:0] act, input logic [M-1:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_ready(input int sel);
        int w = 0;
        @(negedge clk);
        while (!rdy[sel] && w < 400) begin
            @(negedge clk);
            w++;
        end
    endtask

    // lat counts cycles from the cycle start is presented to the cycle done is high.
    task automatic run_op(input int sel, input logic [M-1:0] a, input logic [M-1:0] b,
                          output logic [M-1:0] r, output int lat, output bit hs_ok);
        hs_ok = 1'b1;
        wait_ready(sel);
        a_v = a;
        b_v = b;
        start_v[sel] = 1'b1;
        @(posedge clk);
        #1;
        start_v[sel] = 1'b0;
        lat = 2;
        while (!dn[sel] && lat < 400) begin
            if (rdy[sel] || !bsy[sel]) hs_ok = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
        if (!dn[sel]) hs_ok = 1'b0;
        r = res[sel];
    endtask

    typedef struct {
        logic [M-1:0] a;
        logic [M-1:0] b;
        logic [M-1:0] exp;
    } vec_t;

    initial begin
        vec_t         tbl [7];
        logic [M-1:0] top, r, e, a, b;
        int           lat, pulses, last;
        bit           hs_ok;

        rst     = 1'b1;
        start_v = '0;
        a_v     = '0;
        b_v     = '0;
        top     = '0;
        top[M-1] = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        chk_int("reset ready", int'(rdy[2]), 1);
        chk_int("reset busy", int'(bsy[2]), 0);
        chk_int("reset done", int'(dn[2]), 0);
        chk("reset result", res[2], '0);
        @(negedge clk);
        rst = 1'b0;

        tbl[0] = '{a: 163'd1, b: 163'd1, exp: 163'd1};
        tbl[1] = '{a: 163'd2, b: top, exp: 163'hC9};
        tbl[2] = '{a: top, b: 163'd2, exp: 163'hC9};
        tbl[3] = '{a: 163'd3, b: 163'd3, exp: 163'd5};
        tbl[4] = '{a: top, b: top, exp: ref_mul(top, top)};
        tbl[5] = '{a: 163'd0, b: rnd_op(), exp: 163'd0};
        tbl[6] = '{a: 163'h80, b: 163'h100, exp: 163'h8000};

        for (int i = 0; i < 7; i++) begin
            run_op(2, tbl[i].a, tbl[i].b, r, lat, hs_ok);
            chk($sformatf("table[%0d] result", i), r, tbl[i].exp);
            if (i == 0) begin
                chk_int("table[0] latency", lat, 13);
                chk_int("table[0] ready/busy during run", int'(hs_ok), 1);
            end
        end

        // start with new operands while running must be ignored.
        a = rnd_op();
        b = rnd_op();
        e = ref_mul(a, b);
        wait_ready(2);
        a_v = a;
        b_v = b;
        start_v[2] = 1'b1;
        @(posedge clk);
        #1;
        start_v[2] = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        a_v = rnd_op();
        b_v = rnd_op();
        start_v[2] = 1'b1;
        repeat (3) @(negedge clk);
        start_v[2] = 1'b0;
        pulses = 0;
        r = '0;
        for (int c = 0; c < 25; c++) begin
            @(posedge clk);
            #1;
            if (dn[2]) begin
                pulses++;
                r = res[2];
            end
        end
        chk_int("busy start pulses", pulses, 1);
        chk("busy start result", r, e);

        // start held high: back-to-back operations, one every N+2 cycles.
        a = rnd_op();
        b = rnd_op();
        e = ref_mul(a, b);
        wait_ready(2);
        a_v = a;
        b_v = b;
        start_v[2] = 1'b1;
        pulses = 0;
        last = -1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            if (dn[2]) begin
                pulses++;
                if (last >= 0) chk_int("b2b interval", c - last, 13);
                chk("b2b result", res[2], e);
                last = c;
            end
        end
        start_v[2] = 1'b0;
        chk_int("b2b pulses", pulses, 3);

        // Reset in the middle of an operation.
        wait_ready(2);
        a_v = rnd_op();
        b_v = rnd_op();
        start_v[2] = 1'b1;
        @(posedge clk);
        #1;
        start_v[2] = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk_int("abort ready", int'(rdy[2]), 1);
        chk_int("abort busy", int'(bsy[2]), 0);
        chk_int("abort done", int'(dn[2]), 0);
        chk("abort result", res[2], '0);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (dn[2]) pulses++;
        end
        chk_int("abort no done", pulses, 0);
        run_op(2, 163'd3, 163'd3, r, lat, hs_ok);
        chk("after abort 3*3", r, 163'd5);

        // Random operands against the reference for each digit size.
        for (int s = 0; s < 4; s++) begin
            for (int n = 0; n < int'(NR[s]); n++) begin
                a = rnd_op();
                b = rnd_op();
                run_op(s, a, b, r, lat, hs_ok);
                chk($sformatf("rand D=%0d #%0d", DV[s], n), r, ref_mul(a, b));
                if (n == 0) begin
                    chk_int($sformatf("latency D=%0d", DV[s]), lat, exp_lat(s));
                    chk_int($sformatf("handshake D=%0d", DV[s]), int'(hs_ok), 1);
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
